hazard_ctrl: RTL and testbench

- Parametrised load-use hazard and forwarding controller for the 5-stage pipelined RISC-V core; sits between ID/EX/MEM pipeline registers and the PC/IF-ID enable and flush logic.
- Generalises single-cycle load-use stalling to a configurable multi-cycle load stall, adds x0 exemption, per-operand use qualification, and EX/MEM forwarding selects.
- Also handles external multi-cycle busy (e.g. divider), branch-flush cancellation, and a saturating stall-cycle statistics counter.

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use stall, EX/MEM forwarding select, branch flush and stall statistics for a 5-stage core.
// Latency: stall/bubble/flush/fwd are combinational; stall holds the front end while a load or busy EX unit is pending.
module hazard_ctrl #(
    parameter int REG_NUM_WIDTH     = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_WIDTH         = 3,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_NUM_WIDTH-1:0] idRs0,
    input  logic [REG_NUM_WIDTH-1:0] idRs1,
    input  logic                     idUseRs0,
    input  logic                     idUseRs1,
    input  logic                     exMemRead,
    input  logic                     exRegWrite,
    input  logic [REG_NUM_WIDTH-1:0] exRd,
    input  logic                     memRegWrite,
    input  logic [REG_NUM_WIDTH-1:0] memRd,
    input  logic                     exBusy,
    input  logic                     branchTaken,
    output logic                     stall,
    output logic                     bubble,
    output logic                     flush,
    output logic [1:0]               fwdA,
    output logic [1:0]               fwdB,
    output logic [STAT_WIDTH-1:0]    stallCycles
);

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
    localparam bit                    MULTI    = (LOAD_STALL_CYCLES > 1);

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   stall_raw, bubble_raw, flush_raw;
    logic [1:0]             fwd_a_raw, fwd_b_raw;
    logic                   ex_match0, ex_match1, mem_match0, mem_match1;
    logic                   load_use, ex_alu;

    // x0 is hard-wired zero: it never creates a hazard and never forwards.
    assign ex_match0  = idUseRs0 && (idRs0 != '0) && (idRs0 == exRd);
    assign ex_match1  = idUseRs1 && (idRs1 != '0) && (idRs1 == exRd);
    assign mem_match0 = memRegWrite && idUseRs0 && (idRs0 != '0) && (idRs0 == memRd);
    assign mem_match1 = memRegWrite && idUseRs1 && (idRs1 != '0) && (idRs1 == memRd);

    assign load_use = exMemRead && exRegWrite && (ex_match0 || ex_match1);
    assign ex_alu   = exRegWrite && !exMemRead;

    // EX result is younger than MEM, so it wins a double match.
    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (ex_alu && ex_match0) begin
            fwd_a_raw = 2'b10;
        end else if (mem_match0) begin
            fwd_a_raw = 2'b01;
        end
        if (ex_alu && ex_match1) begin
            fwd_b_raw = 2'b10;
        end else if (mem_match1) begin
            fwd_b_raw = 2'b01;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        flush_raw  = 1'b0;
        if (branchTaken) begin
            // Any stalled instruction is on the wrong path; drop the pending bubbles.
            flush_raw = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (exBusy) begin
            stall_raw = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_use) begin
                        stall_raw  = 1'b1;
                        bubble_raw = 1'b1;
                        if (MULTI) begin
                            state_nxt = LOAD_STALL;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    if (cnt == CNT_ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCycles <= '0;
        end else if (stall_raw && (stallCycles != STAT_MAX)) begin
            stallCycles <= stallCycles + STAT_WIDTH'(1);
        end
    end

    assign stall  = reset && stall_raw;
    assign bubble = reset && bubble_raw;
    assign flush  = reset && flush_raw;
    assign fwdA   = reset ? fwd_a_raw : 2'b00;
    assign fwdB   = reset ? fwd_b_raw : 2'b00;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three hazard_ctrl instances (1, 3 and 4 load bubbles; the last with a 4-bit counter) on shared stimulus.
// Latency: outputs sampled 1-2 time units after the rising edge; no backpressure in the bench.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] idRs0, idRs1, exRd, memRd;
    logic       idUseRs0, idUseRs1, exMemRead, exRegWrite, memRegWrite, exBusy, branchTaken;

    logic        stall1, bubble1, flush1;
    logic [1:0]  fwdA1, fwdB1;
    logic [15:0] cyc1;
    logic        stall3, bubble3, flush3;
    logic [1:0]  fwdA3, fwdB3;
    logic [15:0] cyc3;
    logic        stall4, bubble4, flush4;
    logic [1:0]  fwdA4, fwdB4;
    logic [3:0]  cyc4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_NUM_WIDTH(5), .LOAD_STALL_CYCLES(1), .CNT_WIDTH(3), .STAT_WIDTH(16)) u1 (
        .clk(clk), .reset(reset), .idRs0(idRs0), .idRs1(idRs1), .idUseRs0(idUseRs0), .idUseRs1(idUseRs1),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd), .memRegWrite(memRegWrite), .memRd(memRd),
        .exBusy(exBusy), .branchTaken(branchTaken), .stall(stall1), .bubble(bubble1), .flush(flush1),
        .fwdA(fwdA1), .fwdB(fwdB1), .stallCycles(cyc1));

    hazard_ctrl #(.REG_NUM_WIDTH(5), .LOAD_STALL_CYCLES(3), .CNT_WIDTH(3), .STAT_WIDTH(16)) u3 (
        .clk(clk), .reset(reset), .idRs0(idRs0), .idRs1(idRs1), .idUseRs0(idUseRs0), .idUseRs1(idUseRs1),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd), .memRegWrite(memRegWrite), .memRd(memRd),
        .exBusy(exBusy), .branchTaken(branchTaken), .stall(stall3), .bubble(bubble3), .flush(flush3),
        .fwdA(fwdA3), .fwdB(fwdB3), .stallCycles(cyc3));

    hazard_ctrl #(.REG_NUM_WIDTH(5), .LOAD_STALL_CYCLES(4), .CNT_WIDTH(3), .STAT_WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .idRs0(idRs0), .idRs1(idRs1), .idUseRs0(idUseRs0), .idUseRs1(idUseRs1),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd), .memRegWrite(memRegWrite), .memRd(memRd),
        .exBusy(exBusy), .branchTaken(branchTaken), .stall(stall4), .bubble(bubble4), .flush(flush4),
        .fwdA(fwdA4), .fwdB(fwdB4), .stallCycles(cyc4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        idRs0 = '0; idRs1 = '0; idUseRs0 = 1'b0; idUseRs1 = 1'b0;
        exMemRead = 1'b0; exRegWrite = 1'b0; exRd = '0;
        memRegWrite = 1'b0; memRd = '0; exBusy = 1'b0; branchTaken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Load in EX writing rd, ID reading rs0 == rd.
    task automatic load_hazard_rs0(input logic [4:0] r);
        exMemRead = 1'b1; exRegWrite = 1'b1; exRd = r;
        idRs0 = r; idUseRs0 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Outputs gated while reset is low, even with hazard/branch/forward inputs active.
        clear_inputs();
        reset = 1'b0;
        load_hazard_rs0(5'd5);
        memRegWrite = 1'b1; memRd = 5'd5; branchTaken = 1'b1;
        tick(); tick();
        check("rst_stall", stall1, 0);
        check("rst_bubble", bubble1, 0);
        check("rst_flush", flush1, 0);
        check("rst_fwdA", fwdA1, 0);
        check("rst_cycles", cyc1, 0);
        clear_inputs();
        reset = 1'b1;
        tick();

        // Single-bubble load-use on rs0, then MEM forward.
        load_hazard_rs0(5'd5);
        #1;
        check("a_stall", stall1, 1);
        check("a_bubble", bubble1, 1);
        check("a_fwdA_load", fwdA1, 0);
        tick();
        exMemRead = 1'b0; exRegWrite = 1'b0; exRd = '0;
        memRegWrite = 1'b1; memRd = 5'd5;
        #1;
        check("a_stall_after", stall1, 0);
        check("a_fwdA_mem", fwdA1, 1);
        check("a_cycles", cyc1, 1);
        do_reset();

        // Three-bubble load-use on rs1; hazard held to confirm no retrigger.
        exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd9; idRs1 = 5'd9; idUseRs1 = 1'b1;
        #1;
        check("b_c0_stall", stall3, 1);
        check("b_c0_bubble", bubble3, 1);
        check("b_c0_fwdB", fwdB3, 0);
        tick(); #1;
        check("b_c1_stall", stall3, 1);
        check("b_c1_bubble", bubble3, 1);
        tick(); #1;
        check("b_c2_stall", stall3, 1);
        tick();
        clear_inputs();
        #1;
        check("b_c3_stall", stall3, 0);
        check("b_c3_bubble", bubble3, 0);
        check("b_cycles", cyc3, 3);
        check("b_u4_still", stall4, 1);
        do_reset();

        // x0 exemption and unused operand.
        exMemRead = 1'b1; exRegWrite = 1'b1; exRd = '0; idRs0 = '0; idUseRs0 = 1'b1;
        memRegWrite = 1'b1; memRd = '0;
        #1;
        check("c_x0_stall", stall1, 0);
        check("c_x0_fwdA", fwdA1, 0);
        exRd = 5'd5; idRs0 = 5'd3; idRs1 = 5'd5; idUseRs1 = 1'b0; memRd = 5'd5;
        #1;
        check("c_unused_stall", stall1, 0);
        check("c_unused_fwdB", fwdB1, 0);
        clear_inputs();
        tick();

        // Branch in the 2nd bubble of a four-bubble stall.
        load_hazard_rs0(5'd5);
        #1;
        check("d_c0_stall", stall4, 1);
        tick();
        branchTaken = 1'b1;
        #1;
        check("d_flush", flush4, 1);
        check("d_stall", stall4, 0);
        check("d_bubble", bubble4, 0);
        tick();
        clear_inputs();
        #1;
        check("d_after_stall", stall4, 0);
        check("d_after_flush", flush4, 0);
        tick(); #1;
        check("d_after2_stall", stall4, 0);
        check("d_cycles", cyc4, 1);
        do_reset();

        // Busy EX unit: stall without bubble, load-use deferred, LOAD_STALL frozen.
        load_hazard_rs0(5'd5);
        exBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("e_busy_stall", stall1, 1);
            check("e_busy_bubble", bubble1, 0);
            tick();
        end
        exBusy = 1'b0;
        #1;
        check("e_drop_stall", stall3, 1);
        check("e_drop_bubble", bubble3, 1);
        tick();
        clear_inputs();
        exBusy = 1'b1;
        #1;
        check("e_frz_stall", stall3, 1);
        check("e_frz_bubble", bubble3, 0);
        tick(); tick();
        exBusy = 1'b0;
        #1;
        check("e_res1_bubble", bubble3, 1);
        tick(); #1;
        check("e_res2_bubble", bubble3, 1);
        tick(); #1;
        check("e_end_stall", stall3, 0);
        check("e_cycles3", cyc3, 10);
        check("e_cycles1", cyc1, 8);
        do_reset();

        // Forwarding priority.
        exRegWrite = 1'b1; exRd = 5'd7; memRegWrite = 1'b1; memRd = 5'd7;
        idRs0 = 5'd7; idUseRs0 = 1'b1; idRs1 = 5'd7; idUseRs1 = 1'b1;
        #1;
        check("f_dbl_fwdA", fwdA1, 2);
        check("f_dbl_fwdB", fwdB1, 2);
        check("f_dbl_stall", stall1, 0);
        exRd = 5'd3;
        #1;
        check("f_mem_fwdA", fwdA1, 1);
        idUseRs0 = 1'b0;
        #1;
        check("f_nouse_fwdA", fwdA1, 0);
        check("f_nouse_fwdB", fwdB1, 1);
        clear_inputs();
        tick();

        // Reset asserted in the middle of a load stall.
        load_hazard_rs0(5'd5);
        tick();
        memRegWrite = 1'b1; memRd = 5'd5; exRegWrite = 1'b0; exMemRead = 1'b0;
        reset = 1'b0;
        #1;
        check("g_stall", stall3, 0);
        check("g_bubble", bubble3, 0);
        check("g_fwdA", fwdA3, 0);
        tick();
        check("g_cycles", cyc3, 0);
        clear_inputs();
        reset = 1'b1;
        #1;
        check("g_idle_stall", stall3, 0);
        tick();

        // Saturation of the 4-bit statistics counter.
        exBusy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        exBusy = 1'b0;
        #1;
        check("h_sat4", cyc4, 15);
        check("h_cnt16", cyc1, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
